// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter sequence generator.
//   state_t   - sequencer FSM states
//   cmd_t     - command record {mode, len, last} at the default length width;
//               the command FIFO stores commands packed in this field order
//   MODE_UP / MODE_DOWN - direction encodings driven on the mode output
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CMD_LEN_W = 8;

    typedef struct packed {
        logic                 mode;
        logic [CMD_LEN_W-1:0] len;
        logic                 last;
    } cmd_t;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/counter_cmd_fifo.sv
// counter_cmd_fifo: small synchronous FIFO holding packed commands.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (empties the FIFO)
//   push, push_data - write one entry (caller guarantees not full)
//   pop, pop_data   - pop_data shows the head entry; pop advances it
//                     (caller guarantees not empty)
//   full, empty     - derived from the registered pointers only
// Handshake: a command is transferred on a cycle where push is high; the
// caller forms push from valid & ready with ready = !full, so a pop in the
// same cycle never makes room for a push.
module counter_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_seq_gen.sv
// counter_seq_gen: queues {mode, len, last} commands and plays them out as
// en/mode pulses to a downstream up/down counter, while predicting the value
// that counter will hold.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   start                       - begin executing queued commands (IDLE/DONE)
//   cmd_valid/cmd_ready         - command handshake, fields cmd_mode/len/last
//   en, mode                    - registered counter enable and direction
//   busy                        - FSM in FETCH or RUN
//   seq_done                    - FSM in DONE
//   exp_count                   - predicted counter value after all enables
//   state                       - current FSM state (debug observation)
module counter_seq_gen
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_last,
    output logic             en,
    output logic             mode,
    output logic             busy,
    output logic             seq_done,
    output logic [WIDTH-1:0] exp_count,
    output state_t           state
);

    localparam int CMD_W = LEN_W + 2;

    logic [CMD_W-1:0] push_data;
    logic [CMD_W-1:0] pop_data;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    logic             pop_mode;
    logic [LEN_W-1:0] pop_len;
    logic             pop_last;

    state_t           state_d;
    logic             en_d;
    logic             mode_d;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_d;
    logic             last_q;
    logic             last_d;

    // Commands are packed in cmd_t field order: {mode, len, last}.
    assign push_data = {cmd_mode, cmd_len, cmd_last};
    assign cmd_ready = !full;
    // Nothing is accepted while reset is asserted.
    assign push      = cmd_valid && cmd_ready && rst_n;

    assign pop_mode  = pop_data[CMD_W-1];
    assign pop_len   = pop_data[CMD_W-2:1];
    assign pop_last  = pop_data[0];

    counter_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty)
    );

    assign busy     = (state == FETCH) || (state == RUN);
    assign seq_done = (state == DONE);

    // en is computed one cycle ahead so the registered en is high for every
    // RUN cycle: set on the FETCH->RUN transition, dropped when the last
    // remaining cycle of the command is being played.
    always_comb begin
        state_d = state;
        en_d    = 1'b0;
        mode_d  = mode;
        rem_d   = rem;
        last_d  = last_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!empty) begin
                    pop    = 1'b1;
                    last_d = pop_last;
                    if (pop_len != '0) begin
                        state_d = RUN;
                        en_d    = 1'b1;
                        mode_d  = pop_mode;
                        rem_d   = pop_len;
                    end else if (pop_last) begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // rem counts down from len to 1, so an all-ones length never
                // needs a wider counter.
                rem_d = rem - 1'b1;
                if (rem == LEN_W'(1)) begin
                    state_d = last_q ? DONE : FETCH;
                end else begin
                    en_d = 1'b1;
                end
            end
            DONE: begin
                if (start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            en        <= 1'b0;
            mode      <= MODE_UP;
            rem       <= '0;
            last_q    <= 1'b0;
            exp_count <= '0;
        end else begin
            state  <= state_d;
            en     <= en_d;
            mode   <= mode_d;
            rem    <= rem_d;
            last_q <= last_d;
            // Track the downstream counter: it samples en/mode on this edge.
            if (en) begin
                if (mode == MODE_UP) exp_count <= exp_count + 1'b1;
                else                 exp_count <= exp_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_gen.sv
// Directed bench for counter_seq_gen. Each enabled cycle has an expected
// {mode, exp_count-before-enable} entry queued by the stimulus; the monitor
// pops one entry per en=1 cycle.
module tb_counter_seq_gen;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;
    logic [7:0] cmd_len;
    logic       cmd_last;
    logic       en;
    logic       mode;
    logic       busy;
    logic       seq_done;
    logic [7:0] exp_count;
    state_t     dbg_state;

    int nvec  = 0;
    int nfail = 0;
    int model_cnt = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    counter_seq_gen #(.WIDTH(8), .DEPTH(4), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_len   (cmd_len),
        .cmd_last  (cmd_last),
        .en        (en),
        .mode      (mode),
        .busy      (busy),
        .seq_done  (seq_done),
        .exp_count (exp_count),
        .state     (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every enabled cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && en === 1'b1) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL en_unexpected: got en=1 mode=%0d count=%0d, expected no enable at %0t",
                         mode, exp_count, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({mode, exp_count} !== e) begin
                    nfail++;
                    $display("FAIL en_cycle: got mode=%0d count=%0d expected mode=%0d count=%0d at %0t",
                             mode, exp_count, e[8], e[7:0], $time);
                end
            end
        end
    end

    // Queue expectations for a run of len enables in direction m.
    task automatic expect_run(input logic m, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({m, 8'(model_cnt)});
            model_cnt = m ? (model_cnt + 1) % 256 : (model_cnt + 255) % 256;
        end
    endtask

    task automatic do_reset();
        check("leftover_enables", exp_q.size(), 0);
        exp_q.delete();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic push_cmd(input logic m, input logic [7:0] l, input logic lst);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_len   = l;
        cmd_last  = lst;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 50) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (seq_done) break;
            n++;
            if (n > 600) begin
                check({name, "_done_timeout"}, 0, 1);
                break;
            end
        end
    endtask

    initial begin
        logic [9:0] pat;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        cmd_valid = 1'b1;   // offered during reset: must not be taken
        cmd_mode  = 1'b1;
        cmd_len   = 8'd5;
        cmd_last  = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", en, 0);
        check("rst_mode", mode, 1);
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_exp_count", exp_count, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cmd_valid = 1'b0;

        // Stall on empty FIFO, then zero-length command is skipped
        pulse_start();
        repeat (4) @(negedge clk);
        check("stall_state", dbg_state, FETCH);
        check("stall_en", en, 0);
        check("stall_busy", busy, 1);
        expect_run(1'b1, 2);
        push_cmd(1'b1, 8'd0, 1'b0);
        push_cmd(1'b1, 8'd2, 1'b1);
        wait_done("stall");
        check("stall_exp_count", exp_count, 2);
        check("stall_busy_done", busy, 0);

        // Single command
        do_reset();
        expect_run(1'b1, 5);
        push_cmd(1'b1, 8'd5, 1'b1);
        pulse_start();
        @(negedge clk);
        check("single_fetch_state", dbg_state, FETCH);
        check("single_fetch_en", en, 0);
        @(negedge clk);
        check("single_first_en", en, 1);
        wait_done("single");
        check("single_seq_done", seq_done, 1);
        check("single_exp_count", exp_count, 5);

        // Direction change
        do_reset();
        expect_run(1'b1, 3);
        expect_run(1'b0, 5);
        push_cmd(1'b1, 8'd3, 1'b0);
        push_cmd(1'b0, 8'd5, 1'b1);
        pulse_start();
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat = {pat[8:0], en};
        end
        check("dir_en_pattern", pat, 10'b0111011111);
        wait_done("dir");
        check("dir_exp_count", exp_count, 254);

        // FIFO full
        do_reset();
        expect_run(1'b1, 4);
        push_cmd(1'b1, 8'd1, 1'b0);
        push_cmd(1'b1, 8'd1, 1'b0);
        push_cmd(1'b1, 8'd1, 1'b0);
        push_cmd(1'b1, 8'd1, 1'b1);
        @(negedge clk);
        check("full_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b1;
        cmd_mode = 1'b1;
        cmd_len  = 8'd7;
        cmd_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("full_ready_pop_cycle", cmd_ready, 0);
        @(negedge clk);
        check("full_ready_after_pop", cmd_ready, 1);
        wait_done("full");
        check("full_exp_count", exp_count, 4);

        // Wrap up then down
        do_reset();
        expect_run(1'b1, 255);
        expect_run(1'b1, 2);
        push_cmd(1'b1, 8'd255, 1'b0);
        push_cmd(1'b1, 8'd2, 1'b1);
        pulse_start();
        wait_done("wrap_up");
        check("wrap_up_exp_count", exp_count, 1);
        expect_run(1'b0, 2);
        push_cmd(1'b0, 8'd2, 1'b1);
        pulse_start();
        @(negedge clk);
        check("wrap_restart_seq_done", seq_done, 0);
        wait_done("wrap_down");
        check("wrap_down_exp_count", exp_count, 255);

        // Reset during the third enabled cycle
        do_reset();
        expect_run(1'b1, 3);
        push_cmd(1'b1, 8'd10, 1'b1);
        pulse_start();
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            @(negedge clk);
            if (en) n++;
        end
        check("midrun_reached_third", n, 3);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrun_en", en, 0);
        check("midrun_exp_count", exp_count, 0);
        check("midrun_seq_done", seq_done, 0);
        check("midrun_cmd_ready", cmd_ready, 1);
        pulse_start();
        repeat (4) @(negedge clk);
        check("midrun_fifo_empty_stall", dbg_state, FETCH);
        check("midrun_stall_en", en, 0);

        check("final_leftover_enables", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/counter_seq_gen.md
COUNTER_SEQ_GEN -- requirements
Module: counter_seq_gen

Interface
REQ-001 Parameter WIDTH, default 8: width of exp_count; SHALL match the downstream counter width.
REQ-002 Parameter DEPTH, default 4: command FIFO entries; SHALL be a power of two, 2 or more.
REQ-003 Parameter LEN_W, default 8: width of the command length field.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 start  input  1  one-cycle request to begin executing queued commands.
REQ-007 cmd_valid  input  1  command offered this cycle.
REQ-008 cmd_ready  output  1  command FIFO can accept this cycle.
REQ-009 cmd_mode  input  1  direction: 1 = count up, 0 = count down.
REQ-010 cmd_len  input  LEN_W  number of enabled cycles; 0 = no-op.
REQ-011 cmd_last  input  1  marks the final command of a sequence.
REQ-012 en  output  1  counter enable, driven to the downstream counter.
REQ-013 mode  output  1  counter direction, driven to the downstream counter.
REQ-014 busy  output  1  high when the state is not IDLE or DONE.
REQ-015 seq_done  output  1  level; high in DONE.
REQ-016 exp_count  output  WIDTH  predicted counter value after all enables issued so far.

Function
REQ-017 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; the fields {mode, len, last} SHALL be pushed together.
REQ-018 cmd_ready SHALL equal NOT full, derived from registered FIFO state only; a pop in the same cycle SHALL NOT raise cmd_ready.
REQ-019 The FSM SHALL have the states IDLE, FETCH, RUN and DONE.
REQ-020 IDLE: en=0. On start=1, go to FETCH the next cycle. Commands SHALL still be accepted in IDLE.
REQ-021 FETCH: en=0. If the FIFO is empty, stay in FETCH (stall). Otherwise pop one entry and load len and last.
REQ-022 FETCH, popped len>0: go to RUN.
REQ-023 FETCH, popped len=0 with last=1: go to DONE.
REQ-024 FETCH, popped len=0 with last=0: stay in FETCH.
REQ-025 RUN: en=1 and mode=cmd mode for exactly len consecutive cycles. Afterwards go to DONE if last=1, otherwise to FETCH. This gives one en=0 bubble per command boundary.
REQ-026 The en and mode outputs SHALL be registered. mode SHALL hold its last value when en=0.
REQ-027 DONE: en=0 and seq_done=1. On start=1, clear seq_done and go to FETCH.
REQ-028 start SHALL be ignored in FETCH and RUN.
REQ-029 exp_count SHALL update on every cycle where the en output is 1: +1 when mode=1, -1 when mode=0, modulo 2^WIDTH.
REQ-030 exp_count SHALL wrap 255->0 when counting up and 0->255 when counting down (WIDTH=8).
REQ-031 exp_count SHALL reflect the count after that enable cycle, so that it matches a counter which samples en on the same edge.
REQ-032 A cmd_len of all ones SHALL produce 2^LEN_W-1 enabled cycles, with no overflow of the run counter.

Reset
REQ-033 While rst_n=0 at a clk edge, the following SHALL apply on the next cycle: state=IDLE, en=0, mode=1, busy=0, seq_done=0, exp_count=0, FIFO empty, cmd_ready=1.
REQ-034 Reset asserted mid-RUN SHALL deassert en on the next cycle and discard all queued and in-flight commands.
REQ-035 A command offered during reset SHALL NOT be accepted.

Structure
REQ-036 counter_pkg SHALL hold: the state enum typedef, the command struct typedef {mode, len, last}, and the MODE_UP/MODE_DOWN constants.
REQ-037 The FIFO SHALL be a sub-module named counter_cmd_fifo, parameterized by DEPTH and the packed command width, with push/pop/full/empty ports.
REQ-038 The FSM, the run-length counter and the exp_count predictor SHALL live in counter_seq_gen.

Verification
REQ-039 Single command: push {up,len=5,last=1}, then start -> 1 FETCH cycle, en=1 for 5 cycles, then seq_done=1 and exp_count=5.
REQ-040 Direction change: from reset, run {up,3,0} then {down,5,1} -> en pattern 0,1,1,1,0,1,1,1,1,1 and final exp_count=254.
REQ-041 FIFO full: push 4 commands without start -> cmd_ready=0 on the cycle after the 4th push, and a 5th valid is not accepted. After start and the first pop, cmd_ready returns to 1.
REQ-042 Stall and zero length: start with the FIFO empty -> FETCH holds with en=0. Then push {up,0,0} and {up,2,1} -> en high for exactly 2 cycles, then DONE.
REQ-043 Wrap: push {up,255,0} and {up,2,1} from reset -> exp_count reads 255, then 0 and 1. Then push {down,2,1} and restart -> exp_count 0, then 255.
REQ-044 Reset mid-RUN: assert rst_n=0 during the 3rd enabled cycle of {up,10,1} -> en=0 and exp_count=0 next cycle, FIFO empty, seq_done=0.
